// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - packs Huffman code bundles MSB-first into a byte-stuffed JPEG entropy stream.
module jpeg_bit_packer #(
  parameter int NUM_AC = 8,
  parameter int ACC_W  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  code_length_DC,
  input  logic [19:0] code_out_DC,
  input  logic [4:0]  code_length1,
  input  logic [31:0] code_out1,
  input  logic [4:0]  code_length2,
  input  logic [31:0] code_out2,
  input  logic [4:0]  code_length3,
  input  logic [31:0] code_out3,
  input  logic [4:0]  code_length4,
  input  logic [31:0] code_out4,
  input  logic [4:0]  code_length5,
  input  logic [31:0] code_out5,
  input  logic [4:0]  code_length6,
  input  logic [31:0] code_out6,
  input  logic [4:0]  code_length7,
  input  logic [31:0] code_out7,
  input  logic [4:0]  code_length8,
  input  logic [31:0] code_out8,
  input  logic [4:0]  code_length_table,
  input  logic [31:0] code_out_table,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        flush_done,
  output logic [15:0] byte_count
);

  localparam int NSLOT  = NUM_AC + 2;
  localparam int SLOT_W = $clog2(NSLOT);
  localparam int CNT_W  = $clog2(ACC_W) + 1;

  typedef enum logic [1:0] {IDLE, PACK, PAD, DRAIN} state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [4:0]        len_r  [NSLOT];
  logic [31:0]       code_r [NSLOT];
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              stuff_pending;

  logic        slot_go;
  logic [4:0]  app_len;
  logic [31:0] app_bits;
  logic        load;
  logic        ext;
  logic [7:0]  top_byte;

  assign in_ready = (state == IDLE);

  // Valid bits sit right-aligned in acc; anything above cnt is don't-care.
  always_comb begin
    slot_go  = (state == PACK) && (cnt <= CNT_W'(32));
    app_len  = '0;
    app_bits = '0;
    if (slot_go) begin
      app_len  = len_r[slot];
      app_bits = code_r[slot] & ((32'd1 << len_r[slot]) - 32'd1);
    end else if ((state == PAD) && (cnt[2:0] != 3'd0)) begin
      app_len  = 5'd8 - {2'b00, cnt[2:0]};
      app_bits = (32'd1 << app_len) - 32'd1;
    end
    load     = !out_valid || out_ready;
    ext      = load && !stuff_pending && (cnt >= CNT_W'(8));
    top_byte = 8'(acc >> (cnt - CNT_W'(8)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      slot          <= '0;
      acc           <= '0;
      cnt           <= '0;
      stuff_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_byte      <= 8'h00;
      flush_done    <= 1'b0;
      byte_count    <= 16'd0;
      for (int i = 0; i < NSLOT; i++) begin
        len_r[i]  <= '0;
        code_r[i] <= '0;
      end
    end else begin
      flush_done <= 1'b0;
      acc        <= (acc << app_len) | ACC_W'(app_bits);
      cnt        <= cnt + CNT_W'(app_len) - (ext ? CNT_W'(8) : CNT_W'(0));

      if (load) begin
        if (stuff_pending) begin
          out_byte      <= 8'h00;
          out_valid     <= 1'b1;
          stuff_pending <= 1'b0;
        end else if (ext) begin
          out_byte      <= top_byte;
          out_valid     <= 1'b1;
          stuff_pending <= (top_byte == 8'hFF);
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (out_valid && out_ready)
        byte_count <= byte_count + 16'd1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            len_r[0]        <= code_length_DC;
            code_r[0]       <= {12'd0, code_out_DC};
            len_r[1]        <= code_length1;
            code_r[1]       <= code_out1;
            len_r[2]        <= code_length2;
            code_r[2]       <= code_out2;
            len_r[3]        <= code_length3;
            code_r[3]       <= code_out3;
            len_r[4]        <= code_length4;
            code_r[4]       <= code_out4;
            len_r[5]        <= code_length5;
            code_r[5]       <= code_out5;
            len_r[6]        <= code_length6;
            code_r[6]       <= code_out6;
            len_r[7]        <= code_length7;
            code_r[7]       <= code_out7;
            len_r[8]        <= code_length8;
            code_r[8]       <= code_out8;
            len_r[NSLOT-1]  <= code_length_table;
            code_r[NSLOT-1] <= code_out_table;
            slot            <= '0;
            state           <= PACK;
          end else if (flush) begin
            state <= PAD;
          end
        end
        PACK: begin
          if (slot_go) begin
            if (slot == SLOT_W'(NSLOT - 1))
              state <= IDLE;
            else
              slot <= slot + SLOT_W'(1);
          end
        end
        PAD: state <= DRAIN;
        DRAIN: begin
          // No handshake can be in flight here, so the clear never races an increment.
          if ((cnt == '0) && !stuff_pending && !out_valid) begin
            flush_done <= 1'b1;
            byte_count <= 16'd0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - directed and random checks of jpeg_bit_packer against a bit-queue model.
module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        flush_done;
  logic [15:0] byte_count;
  logic [4:0]  b_len  [10];
  logic [31:0] b_code [10];

  int         total = 0;
  int         bad = 0;
  bit         mq[$];
  logic [7:0] eq[$];
  int         model_bytes = 0;
  int         fd_count = 0;
  bit         hold_low = 1'b0;
  bit         rand_mode = 1'b0;

  always #5 clk = ~clk;

  jpeg_bit_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_length_DC(b_len[0]), .code_out_DC(b_code[0][19:0]),
    .code_length1(b_len[1]), .code_out1(b_code[1]),
    .code_length2(b_len[2]), .code_out2(b_code[2]),
    .code_length3(b_len[3]), .code_out3(b_code[3]),
    .code_length4(b_len[4]), .code_out4(b_code[4]),
    .code_length5(b_len[5]), .code_out5(b_code[5]),
    .code_length6(b_len[6]), .code_out6(b_code[6]),
    .code_length7(b_len[7]), .code_out7(b_code[7]),
    .code_length8(b_len[8]), .code_out8(b_code[8]),
    .code_length_table(b_len[9]), .code_out_table(b_code[9]),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .flush_done(flush_done), .byte_count(byte_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain bit queue turned into stuffed bytes.
  task automatic m_pack_bytes();
    logic [7:0] b;
    while (mq.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = (b << 1) | 8'(mq.pop_front());
      eq.push_back(b);
      model_bytes++;
      if (b == 8'hFF) begin
        eq.push_back(8'h00);
        model_bytes++;
      end
    end
  endtask

  task automatic m_bundle();
    for (int k = 0; k < 10; k++)
      for (int i = int'(b_len[k]) - 1; i >= 0; i--) mq.push_back(b_code[k][i]);
    m_pack_bytes();
  endtask

  task automatic m_flush();
    while (mq.size() % 8 != 0) mq.push_back(1'b1);
    m_pack_bytes();
  endtask

  always @(negedge clk) begin
    if (rst_n && flush_done) fd_count++;
    if (rst_n && out_valid && out_ready) begin
      if (eq.size() == 0) chk("byte_expected", 32'(eq.size() != 0), 32'd1);
      else                chk("out_byte", {24'd0, out_byte}, {24'd0, eq.pop_front()});
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bundle();
    for (int k = 0; k < 10; k++) begin
      b_len[k]  = 5'd0;
      b_code[k] = 32'd0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 5000) begin tick(); n++; end
    chk("idle_reached", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input bit with_flush);
    wait_idle();
    in_valid = 1'b1;
    flush    = with_flush;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    m_bundle();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (eq.size() != 0 && n < 5000) begin tick(); n++; end
    chk("stream_drained", eq.size(), 32'd0);
  endtask

  task automatic do_flush();
    int          n = 0;
    bit          seen = 1'b0;
    logic [15:0] prev;
    wait_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_flush();
    prev = byte_count;
    while (!seen && n < 5000) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
      else prev = byte_count;
      n++;
    end
    chk("flush_done_seen", {31'd0, seen}, 32'd1);
    chk("byte_count_before_clear", {16'd0, prev}, {16'd0, 16'(model_bytes)});
    chk("byte_count_cleared", {16'd0, byte_count}, 32'd0);
    chk("flush_all_bytes_out", eq.size(), 32'd0);
    model_bytes = 0;
    tick();
  endtask

  initial begin
    int seen_ready;
    int fd0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    clr_bundle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // DC 00, table 1010, padded with 11
    clr_bundle();
    b_len[0] = 5'd2; b_code[0] = 32'h0;
    b_len[9] = 5'd4; b_code[9] = 32'hA;
    send(1'b0);
    do_flush();

    // 0xFF is stuffed, already byte-aligned so no pad byte
    clr_bundle();
    b_len[0] = 5'd8; b_code[0] = 32'hFF;
    send(1'b0);
    do_flush();

    // high bits beyond the length are ignored
    clr_bundle();
    b_len[1] = 5'd4; b_code[1] = 32'hFFFF_FFF0;
    b_len[9] = 5'd4; b_code[9] = 32'hF;
    send(1'b0);
    do_flush();

    // backpressure stalls PACK
    hold_low = 1'b1;
    tick();
    clr_bundle();
    for (int k = 1; k <= 8; k++) begin b_len[k] = 5'd31; b_code[k] = 32'h7FFF_FFFF; end
    send(1'b0);
    seen_ready = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready) seen_ready++;
    end
    chk("stall_in_ready_low", seen_ready, 32'd0);
    chk("stall_out_valid_held", {31'd0, out_valid}, 32'd1);
    chk("stall_out_byte_held", {24'd0, out_byte}, {24'd0, eq[0]});
    hold_low = 1'b0;
    wait_drain();
    do_flush();

    // reset mid-bundle
    clr_bundle();
    b_len[0] = 5'd16; b_code[0] = 32'h1234;
    send(1'b0);
    wait_drain();
    hold_low = 1'b1;
    tick();
    clr_bundle();
    for (int k = 0; k < 4; k++) begin b_len[k] = 5'd8; b_code[k] = $urandom(); end
    send(1'b0);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_byte_count", {16'd0, byte_count}, 32'd0);
    mq.delete(); eq.delete(); model_bytes = 0;
    tick();
    rst_n = 1'b1;
    hold_low = 1'b0;
    tick();
    clr_bundle();
    b_len[0] = 5'd6; b_code[0] = $urandom();
    b_len[9] = 5'd5; b_code[9] = $urandom();
    send(1'b0);
    do_flush();

    // in_valid beats a simultaneous flush
    clr_bundle();
    b_len[0] = 5'd7; b_code[0] = $urandom();
    b_len[3] = 5'd9; b_code[3] = $urandom();
    fd0 = fd_count;
    send(1'b1);
    wait_idle();
    repeat (30) tick();
    chk("flush_ignored", fd_count - fd0, 32'd0);
    fd0 = fd_count;
    do_flush();
    repeat (5) tick();
    chk("single_flush_pulse", fd_count - fd0, 32'd1);

    // random bundles with random backpressure
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 10; k++) begin
        b_len[k]  = (k == 0) ? 5'($urandom_range(0, 20)) : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) b_len[k] = 5'd0;
        b_code[k] = $urandom();
      end
      send(1'b0);
      if ($urandom_range(0, 5) == 0) do_flush();
    end
    do_flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_bit_packer.md
Name: jpeg_bit_packer

Overview:
- Sits directly downstream of the Huffman encoder.
- Takes one block-bundle of variable-length codes per handshake: one DC code, eight AC codes and one table code (EOB/ZRL).
- Serialises the bundle MSB-first into a continuous JPEG entropy-coded bitstream and emits it one byte at a time.
- Inserts 0x00 after every emitted 0xFF (byte stuffing) and supports an end-of-scan flush that pads with 1s.

Parameters:
- NUM_AC, 8, number of AC code slots per bundle.
- ACC_W, 64, bit-accumulator width; must be ≥ 2×32.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  bundle valid.
- in_ready  output  1  bundle accepted when in_valid & in_ready.
- code_length_DC  input  5  DC code length, 0..20.
- code_out_DC  input  20  DC code, right-aligned.
- code_length1..8  input  5 each  AC code lengths, 0..31.
- code_out1..8  input  32 each  AC codes, right-aligned.
- code_length_table  input  5  table code length, 0..31.
- code_out_table  input  32  table code, right-aligned.
- flush  input  1  end-of-scan request, sampled only in IDLE.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  downstream accepts byte when out_valid & out_ready.
- out_byte  output  8  stream byte.
- flush_done  output  1  one-cycle pulse when flush is complete.
- byte_count  output  16  bytes emitted since reset or last flush_done, stuffed bytes included.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, accumulator and bit count cleared, stuff_pending=0.
  - out_valid=0, out_byte=0x00, flush_done=0, byte_count=0.
  - in_ready=1; it is decoded from state and equals 1 whenever state is IDLE.
- A reset mid-bundle discards all buffered bits and the pending byte, with no output.
- States:
  - IDLE: in_ready=1.
    - On in_valid, capture all 10 slots into registers and go to PACK with slot=0.
    - Otherwise, if flush is high, go to PAD.
    - in_valid has priority over a simultaneous flush; flush is then ignored and must be re-asserted.
  - PACK: appends one slot per cycle in the order DC, AC1..AC8, table.
    - A slot is appended only when bit count ≤ 32; otherwise the cycle is a stall.
    - A zero-length slot takes one cycle and appends nothing.
    - Only the low L bits of a code are used; higher bits are ignored.
    - After the table slot is appended, go to IDLE. One bundle takes a minimum of 10 cycles.
  - PAD: if bit count mod 8 ≠ 0, append 1-bits up to the next byte boundary. Go to DRAIN.
  - DRAIN: wait until bit count=0, stuff_pending=0 and out_valid=0.
    - Then pulse flush_done for one cycle, clear byte_count in that same cycle, and go to IDLE.
- Byte emission (valid-ready): runs concurrently in every state.
  - Load out_byte when out_valid=0, or when out_valid & out_ready.
  - If stuff_pending: load 0x00 and clear stuff_pending.
  - Else if bit count ≥ 8: load the top 8 buffered bits, reduce bit count by 8, and set stuff_pending if that byte is 0xFF.
  - Else: out_valid goes to 0.
  - out_byte and out_valid stay stable while out_valid & !out_ready.
  - Append and byte extraction may occur in the same cycle. The net bit count is count + L − 8.
- byte_count increments on each out_valid & out_ready and wraps 65535→0.
- Bits leave in exact append order; no bits are dropped or duplicated under any out_ready pattern.

Test Plan:
1. DC=0b00 len2, AC1..8 len0, table=0b1010 len4, then flush → single byte 0x2B (001010 + pad 11), then flush_done pulse, byte_count=1 before the clear.
2. DC=0xFF len8, all other lengths 0, flush → bytes 0xFF, 0x00; byte_count=2; no pad byte, since the stream is byte-aligned.
3. code_out1=0xFFFFFFF0 len4, DC len0, table len4 =0xF, flush → byte 0x0F; the high bits of code_out1 are ignored.
4. All eight AC codes =0x7FFFFFFF len31, out_ready held low for 20 cycles → PACK stalls at bit count >32; in_ready stays 0.
   - After release, 31 bytes of 0xFF each followed by 0x00 (62 bytes total) are emitted, in order.
5. rst_n pulsed low during PACK with 3 bytes buffered → out_valid=0 immediately; in_ready=1; byte_count=0; the next bundle packs from an empty accumulator.
6. in_valid and flush asserted together in IDLE → bundle accepted, flush ignored, no flush_done. A later standalone flush pulses flush_done exactly once.
